// File: rtl/contador_pkg.sv
// Shared constants and helpers for the parameterised BCD counter.
// Latency: none (package only).
// Backpressure: none (package only).
package contador_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         NDIG_MAX = 8;

    // Builds a vector with the lowest ndig nibbles set to 9 and the rest 0.
    function automatic logic [NDIG_MAX*BCD_W-1:0] all_nines(input int ndig);
        logic [NDIG_MAX*BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG_MAX; i++) begin
            if (i < ndig) begin
                r[i*BCD_W +: BCD_W] = BCD_MAX;
            end
        end
        return r;
    endfunction

    // Any nibble above 9 is not a BCD digit; pin it to 9.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digito.sv
// One BCD digit: registered value with load, carry-in increment and borrow-in decrement.
// Latency: value updates at the clock edge the command is sampled; carry/borrow out are combinational.
// Backpressure: none; a command is applied every cycle it is presented.
module bcd_digito
    import contador_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             cin_i,
    input  logic             bin_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             cout_o,
    output logic             bout_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    // Next digit: load wins, then increment with 9->0 roll, then decrement with 0->9 roll.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = clamp_digit(load_val_i);
        end else if (cin_i) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
        end else if (bin_i) begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // Digit register with synchronous reset to 0.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign cout_o  = cin_i & (digit_q == BCD_MAX);
    assign bout_o  = bin_i & (digit_q == '0);

endmodule

// File: rtl/contador_bcd_param.sv
// NDIG-digit BCD up/down counter driven by inc/dec rising edges, with load, wrap or saturate,
// and optional auto-restock on underflow (enabled by defining CONTADOR_AUTO_REPOR_EN).
// Latency: bcd/estouro/repor_pulso change at the edge where the input rise is sampled; no backpressure.
module contador_bcd_param
    import contador_pkg::*;
#(
    parameter int                      NDIG        = 2,
    parameter int                      WRAP        = 1,
    parameter logic [BCD_W*NDIG-1:0]   REPOR_VALOR = (BCD_W*NDIG)'(all_nines(NDIG))
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    load,
    input  logic [BCD_W*NDIG-1:0]   load_val,
    output logic [BCD_W*NDIG-1:0]   bcd,
    output logic                    zero,
    output logic                    cheio,
    output logic                    estouro,
    output logic                    repor_pulso
);

    localparam int                        W          = BCD_W * NDIG;
    localparam logic [NDIG_MAX*BCD_W-1:0] NINES_FULL = all_nines(NDIG);
    localparam logic [W-1:0]              NINES      = NINES_FULL[W-1:0];

`ifdef CONTADOR_AUTO_REPOR_EN
    localparam logic AUTO_REPOR = 1'b1;
`else
    localparam logic AUTO_REPOR = 1'b0;
`endif

    logic         inc_hist_q;
    logic         dec_hist_q;
    logic         estouro_q;
    logic         estouro_d;
    logic         inc_edge;
    logic         dec_edge;
    logic         up_req;
    logic         dn_req;
    logic         sat_up;
    logic         sat_dn;
    logic         up_go;
    logic         dn_go;
    logic         carry_top;
    logic         borrow_top;
    logic         restock;
    logic         dig_ld;
    logic [W-1:0] dig_ld_val;
    logic [W-1:0] bcd_w;

    assign inc_edge = inc & ~inc_hist_q;
    assign dec_edge = dec & ~dec_hist_q;

    // Simultaneous inc and dec edges cancel; a load discards any edge.
    assign up_req = inc_edge & ~dec_edge & ~load;
    assign dn_req = dec_edge & ~inc_edge & ~load;

    // In saturate mode a limit-crossing step is blocked before it reaches the digits.
    // With auto-restock the underflow step is instead overridden by the restock load.
    assign sat_up = up_req & cheio & (WRAP == 0);
    assign sat_dn = dn_req & zero & (WRAP == 0) & ~AUTO_REPOR;
    assign up_go  = up_req & ~sat_up;
    assign dn_go  = dn_req & ~sat_dn;

    assign restock    = AUTO_REPOR & borrow_top;
    assign dig_ld     = load | restock;
    assign dig_ld_val = load ? load_val : REPOR_VALOR;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        logic cin_w;
        logic bin_w;
        logic cout_w;
        logic bout_w;

        if (g == 0) begin : g_lsd
            assign cin_w = up_go;
            assign bin_w = dn_go;
        end else begin : g_chain
            assign cin_w = g_dig[g-1].cout_w;
            assign bin_w = g_dig[g-1].bout_w;
        end

        bcd_digito u_dig (
            .clock_i    (clock),
            .reset_i    (reset),
            .cin_i      (cin_w),
            .bin_i      (bin_w),
            .load_i     (dig_ld),
            .load_val_i (dig_ld_val[g*BCD_W +: BCD_W]),
            .digit_o    (bcd_w[g*BCD_W +: BCD_W]),
            .cout_o     (cout_w),
            .bout_o     (bout_w)
        );
    end

    // Carry/borrow out of the top digit means the count wrapped past a limit.
    assign carry_top  = g_dig[NDIG-1].cout_w;
    assign borrow_top = g_dig[NDIG-1].bout_w;

    // Overflow flag: wrap or blocked saturation; a restocked underflow is not an overflow.
    always_comb begin
        estouro_d = 1'b0;
        if (carry_top || sat_up) begin
            estouro_d = 1'b1;
        end else if ((borrow_top || sat_dn) && !AUTO_REPOR) begin
            estouro_d = 1'b1;
        end
    end

    // Edge history tracks input levels every cycle, including during reset,
    // so a level held high across reset release is not seen as a new edge.
    always_ff @(posedge clock) begin
        inc_hist_q <= inc;
        dec_hist_q <= dec;
    end

    // Registered overflow pulse, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estouro_q <= 1'b0;
        end else begin
            estouro_q <= estouro_d;
        end
    end

`ifdef CONTADOR_AUTO_REPOR_EN
    logic repor_q;

    // Registered restock pulse, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            repor_q <= 1'b0;
        end else begin
            repor_q <= restock;
        end
    end

    assign repor_pulso = repor_q;
`else
    assign repor_pulso = 1'b0;
`endif

    assign bcd     = bcd_w;
    assign zero    = (bcd_w == '0);
    assign cheio   = (bcd_w == NINES);
    assign estouro = estouro_q;

endmodule

// File: tb/tb_contador_bcd_param.sv
// Bench for contador_bcd_param: two instances (wrap and saturate) share stimulus and
// are compared every cycle against an integer-valued reference model, plus literal checks.
module tb_contador_bcd_param;

    localparam int         NDIG = 2;
    localparam int         W    = 4 * NDIG;
    localparam int         MAXV = 99;
    localparam logic [7:0] RV   = 8'h48;

`ifdef CONTADOR_AUTO_REPOR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         inc;
    logic         dec;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] bcd_a,  bcd_b;
    logic         zero_a, zero_b;
    logic         cheio_a, cheio_b;
    logic         est_a,  est_b;
    logic         rp_a,   rp_b;

    always #5 clock = ~clock;

    contador_bcd_param #(.NDIG(NDIG), .WRAP(1), .REPOR_VALOR(RV)) u_wrap (
        .clock(clock), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .bcd(bcd_a), .zero(zero_a), .cheio(cheio_a),
        .estouro(est_a), .repor_pulso(rp_a)
    );

    contador_bcd_param #(.NDIG(NDIG), .WRAP(0), .REPOR_VALOR(RV)) u_sat (
        .clock(clock), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .bcd(bcd_b), .zero(zero_b), .cheio(cheio_b),
        .estouro(est_b), .repor_pulso(rp_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal value of a BCD word, with nibbles above 9 read as 9.
    function automatic int bcd2int(input logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = int'((b >> (4 * i)) & 'hF);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: index 0 is the wrapping counter, index 1 the saturating one.
    int m_val [2];
    bit m_ov  [2];
    bit m_rp  [2];
    bit m_pi, m_pd, m_ie, m_de;
    bit chk_en = 1'b0;

    always @(posedge clock) begin
        m_ie = inc && !m_pi;
        m_de = dec && !m_pd;
        m_pi = inc;
        m_pd = dec;
        for (int w = 0; w < 2; w++) begin
            m_ov[w] = 1'b0;
            m_rp[w] = 1'b0;
            if (reset) begin
                m_val[w] = 0;
            end else if (load) begin
                m_val[w] = bcd2int(load_val);
            end else if (m_ie && !m_de) begin
                if (m_val[w] == MAXV) begin
                    m_ov[w]  = 1'b1;
                    m_val[w] = (w == 0) ? 0 : MAXV;
                end else begin
                    m_val[w] = m_val[w] + 1;
                end
            end else if (m_de && !m_ie) begin
                if (m_val[w] == 0) begin
                    if (AUTO) begin
                        m_val[w] = bcd2int(RV);
                        m_rp[w]  = 1'b1;
                    end else begin
                        m_ov[w]  = 1'b1;
                        m_val[w] = (w == 0) ? MAXV : 0;
                    end
                end else begin
                    m_val[w] = m_val[w] - 1;
                end
            end
        end
        if (reset) chk_en = 1'b1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("bcd_wrap",   bcd_a,   int2bcd(m_val[0]));
            chk("zero_wrap",  zero_a,  m_val[0] == 0);
            chk("cheio_wrap", cheio_a, m_val[0] == MAXV);
            chk("est_wrap",   est_a,   m_ov[0]);
            chk("rp_wrap",    rp_a,    m_rp[0]);
            chk("excl_wrap",  est_a & rp_a, 0);
            chk("bcd_sat",    bcd_b,   int2bcd(m_val[1]));
            chk("zero_sat",   zero_b,  m_val[1] == 0);
            chk("cheio_sat",  cheio_b, m_val[1] == MAXV);
            chk("est_sat",    est_b,   m_ov[1]);
            chk("rp_sat",     rp_b,    m_rp[1]);
            chk("excl_sat",   est_b & rp_b, 0);
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int r;
        reset    = 1'b1;
        inc      = 1'b0;
        dec      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_bcd_a", bcd_a, 8'h00);
        chk("rst_zero_a", zero_a, 1);
        chk("rst_est_a", est_a, 0);

        // Twelve inc edges: carry at the tenth.
        for (int i = 1; i <= 12; i++) begin
            inc = 1'b1;
            step();
            inc = 1'b0;
            if (i == 9)  chk("cnt9_bcd", bcd_a, 8'h09);
            if (i == 10) chk("cnt10_carry", bcd_a, 8'h10);
            step();
        end
        chk("cnt12_bcd_a", bcd_a, 8'h12);
        chk("cnt12_bcd_b", bcd_b, 8'h12);
        chk("cnt12_zero", zero_a, 0);
        chk("model_12", int2bcd(m_val[0]), 8'h12);

        // Load 99 then increment: wrap to 00 vs hold at 99.
        load_val = 8'h99;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ld99_cheio", cheio_a, 1);
        inc = 1'b1;
        step();
        inc = 1'b0;
        chk("ovf_wrap_bcd", bcd_a, 8'h00);
        chk("ovf_wrap_est", est_a, 1);
        chk("ovf_sat_bcd", bcd_b, 8'h99);
        chk("ovf_sat_est", est_b, 1);
        step();
        chk("ovf_wrap_est_end", est_a, 0);
        chk("ovf_sat_est_end", est_b, 0);

        // Decrement at zero.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        dec = 1'b1;
        step();
        dec = 1'b0;
`ifdef CONTADOR_AUTO_REPOR_EN
        chk("unf_repor_bcd", bcd_b, 8'h48);
        chk("unf_repor_rp", rp_b, 1);
        chk("unf_repor_est", est_b, 0);
`else
        chk("unf_sat_bcd", bcd_b, 8'h00);
        chk("unf_sat_est", est_b, 1);
        chk("unf_wrap_bcd", bcd_a, 8'h99);
        chk("unf_wrap_est", est_a, 1);
        chk("model_unf", int2bcd(m_val[0]), 8'h99);
`endif
        step();
        chk("unf_est_end", est_b, 0);

`ifdef CONTADOR_AUTO_REPOR_EN
        // From 01: two decrements give 00 then the restock value.
        load_val = 8'h01;
        load = 1'b1;
        step();
        load = 1'b0;
        dec = 1'b1;
        step();
        dec = 1'b0;
        chk("rp_first_bcd", bcd_a, 8'h00);
        chk("rp_first_rp", rp_a, 0);
        step();
        dec = 1'b1;
        step();
        dec = 1'b0;
        chk("rp_second_bcd", bcd_a, 8'h48);
        chk("rp_second_rp", rp_a, 1);
        chk("rp_second_est", est_a, 0);
        step();
        chk("rp_end", rp_a, 0);
`endif

        // Simultaneous inc and dec edges cancel.
        load_val = 8'h37;
        load = 1'b1;
        step();
        load = 1'b0;
        inc = 1'b1;
        dec = 1'b1;
        step();
        chk("both_bcd", bcd_a, 8'h37);
        chk("both_est", est_a, 0);
        inc = 1'b0;
        dec = 1'b0;
        step();

        // inc held high across reset release.
        inc = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        chk("held_inc_bcd", bcd_a, 8'h00);
        inc = 1'b0;
        step();

        // Invalid nibbles clamp; load beats a coincident inc edge.
        load_val = 8'hAF;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("clamp_bcd", bcd_a, 8'h99);
        load_val = 8'h25;
        load = 1'b1;
        inc = 1'b1;
        step();
        load = 1'b0;
        inc = 1'b0;
        chk("ld_inc_bcd", bcd_a, 8'h25);
        chk("ld_inc_est", est_a, 0);
        step();
        chk("ld_inc_hold", bcd_b, 8'h25);

        // Random traffic, biased toward the limits.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0:       load_val = 8'h99;
                1:       load_val = 8'h00;
                2:       load_val = 8'h01;
                3:       load_val = 8'h98;
                default: load_val = 8'($urandom_range(0, 255));
            endcase
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
